seq_det_sched: RTL and testbench
================================

// Module: seq_det_sched
// PURPOSE
//  Shares one serial 011/100 pattern detector between two parallel requesters.
//  - Arbitrates round-robin between the requesters.
//  - Serialises the granted DW-bit word into the detector, MSB first.
//  - Counts the detector's 011 hits and 100 hits over that word.
//  - Returns both counts with a one-cycle done pulse.
//  Sits between a word-oriented producer (e.g. bus/UART side) and the bit-serial detector.
// PARAMETERS
//  DW  8  word width in bits; number of bits serialised per frame
//  CW  4  width of each hit counter; the counters saturate at all-ones
// PORTS
//  ck      in   1   clock; all state updates on the rising edge
//  rs      in   1   reset, asynchronous, active-high
//  req0    in   1   requester 0 has a word; held with data0 stable until gnt[0]
//  data0   in   DW  requester 0 word
//  req1    in   1   requester 1 has a word; held with data1 stable until gnt[1]
//  data1   in   DW  requester 1 word
//  gnt     out  2   one-hot grant; high for 1 cycle
//  busy    out  1   high in every state except IDLE
//  s_out   out  1   serial bit currently presented to the detector
//  done    out  1   1-cycle pulse: cnt011, cnt100 and owner are valid
//  owner   out  1   index of the requester whose word produced the counts
//  cnt011  out  CW  number of 011 detections in the frame
//  cnt100  out  CW  number of 100 detections in the frame
// BEHAVIOUR
//  Reset (rs=1, at any time, including mid-frame):
//   - Controller returns to IDLE; detector core returns to START.
//   - gnt=0, busy=0, s_out=0, done=0, owner=0, cnt011=0, cnt100=0.
//   - Round-robin pointer is set so that req0 wins the first tie.
//  Controller FSM: IDLE -> SHIFT -> FLUSH -> DONE -> IDLE.
//  IDLE, on an edge with any req high:
//   - Pick the winner: a single requester wins outright; on a tie, the requester not served last wins.
//   - Load shift register <= winner's data; owner <= winner.
//   - Clear both counters; synchronously clear the core to START; bit index <= 0.
//   - gnt <= onehot(winner), so gnt is high during the first SHIFT cycle only.
//  SHIFT: s_out = sr[DW-1]; each edge the core consumes s_out and sr shifts left.
//   - Leave for FLUSH after DW edges.
//  FLUSH: 1 cycle; the core holds its state after the last bit, so its output covers the final bit.
//  Counting: in SHIFT and FLUSH, each cycle with hit011 (hit100) high increments cnt011 (cnt100) by 1.
//   - Increments saturate at 2^CW-1.
//  DONE: done=1 for 1 cycle, then IDLE.
//   - owner and counts hold until the next grant.
//   - A req pending during DONE is granted on the IDLE edge that follows.
//  Latency: done is high in the cycle DW+1 edges after the grant edge.
//   - Back-to-back frames cost DW+3 cycles each.
//  req/data changes while busy are ignored (word already latched).
//  s_out = 0 outside SHIFT.
//  Detector core: Moore, 7 states; patterns may overlap; patterns never span frames (cleared at grant).
//   START: 0->S0, 1->S1
//   S0:    0->S0, 1->S01
//   S01:   0->S10, 1->S011
//   S011:  0->S10, 1->S1
//   S1:    0->S10, 1->S1
//   S10:   0->S100, 1->S01
//   S100:  0->S0, 1->S01
//   Unused encoding -> START.
//   hit011 = (state==S011); hit100 = (state==S100); both 0 in every other state.
// STRUCTURE
//  seq_det_pkg:
//   - detector state encodings (START=0 .. S100=6)
//   - controller state encodings (IDLE, SHIFT, FLUSH, DONE)
//  Sub-module seq_det_core:
//   - ports ck, rs, clr, s, hit011, hit100
//   - clocked on the rising edge, async rs
//   - instantiated once
//  Arbiter, shifter, bit index and counters live in seq_det_sched.
// TESTING
//  1. Reset then idle: req0=req1=0 -> busy=0, gnt=0, done=0, all counts 0, s_out=0.
//  2. req0, data0=8'b0110_1100 -> gnt=2'b01 for 1 cycle.
//     s_out serial sequence: 0,1,1,0,1,1,0,0.
//     done 9 edges after grant edge, with owner=0, cnt011=2, cnt100=1.
//  3. req1, data1=8'b1001_0010 -> cnt011=0, cnt100=2, owner=1.
//     data1=8'hFF -> counts 0,0; data1=8'h00 -> counts 0,0.
//  4. req0 and req1 both high from reset -> req0 served first, req1 next.
//     With both held, grants alternate 01,10,01.
//     Frame period is 11 cycles.
//  5. rs pulsed during SHIFT bit 4 -> immediate IDLE with all outputs 0, no done.
//     After rs drops, a held req0 is re-granted and its frame completes with the correct counts.
//  6. Changing data0 mid-frame -> counts reflect the word latched at grant.
//     Core is cleared between frames: frame A ends 8'b...01 and frame B starts 1...; no 011 hit spans the boundary.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared encodings for the serial 011/100 detector and its frame scheduler.
package seq_det_pkg;

  // Detector core states (Moore, 3-bit encoding; 7 is unused and recovers to START)
  localparam logic [2:0] DET_START = 3'd0;
  localparam logic [2:0] DET_S0    = 3'd1;
  localparam logic [2:0] DET_S01   = 3'd2;
  localparam logic [2:0] DET_S011  = 3'd3;
  localparam logic [2:0] DET_S1    = 3'd4;
  localparam logic [2:0] DET_S10   = 3'd5;
  localparam logic [2:0] DET_S100  = 3'd6;

  // Scheduler controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // One-hot grant vector for a requester index
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Next detector state for one serial input bit
  function automatic logic [2:0] det_next(input logic [2:0] cur, input logic s);
    logic [2:0] nxt;
    nxt = DET_START;
    case (cur)
      DET_START: nxt = s ? DET_S1   : DET_S0;
      DET_S0:    nxt = s ? DET_S01  : DET_S0;
      DET_S01:   nxt = s ? DET_S011 : DET_S10;
      DET_S011:  nxt = s ? DET_S1   : DET_S10;
      DET_S1:    nxt = s ? DET_S1   : DET_S10;
      DET_S10:   nxt = s ? DET_S01  : DET_S100;
      DET_S100:  nxt = s ? DET_S01  : DET_S0;
      default:   nxt = DET_START;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Requester/result bundle between the word-side producer and the scheduler.
interface seq_det_sched_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4
);
  logic          req0;
  logic [DW-1:0] data0;
  logic          req1;
  logic [DW-1:0] data1;
  logic [1:0]    gnt;
  logic          busy;
  logic          s_out;
  logic          done;
  logic          owner;
  logic [CW-1:0] cnt011;
  logic [CW-1:0] cnt100;

  // Producer side: raises requests, observes grant and results
  modport master (
    output req0, data0, req1, data1,
    input  gnt, busy, s_out, done, owner, cnt011, cnt100
  );

  // Scheduler side
  modport slave (
    input  req0, data0, req1, data1,
    output gnt, busy, s_out, done, owner, cnt011, cnt100
  );
endinterface

// File: rtl/seq_det_core.sv
// Bit-serial overlapping 011/100 detector (Moore); hits decode the current state.
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic ck,
  input  logic rs,
  input  logic clr,
  input  logic s,
  output logic hit011,
  output logic hit100
);

  logic [2:0] r_state;
  logic [2:0] w_next;

  // Next-state decode for the current serial bit
  always_comb begin
    w_next = det_next(r_state, s);
  end

  // State register; clr restarts pattern matching so hits never span frames
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      r_state <= DET_START;
    end else if (clr) begin
      r_state <= DET_START;
    end else begin
      r_state <= w_next;
    end
  end

  assign hit011 = (r_state == DET_S011);
  assign hit100 = (r_state == DET_S100);

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial 011/100 detector between two
// word-wide requesters: latch a word, shift it MSB first, count hits, report.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4
) (
  input  logic             ck,
  input  logic             rs,
  seq_det_sched_if.slave   bus
);

  localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;

  logic [1:0]    r_ctl;
  logic [DW-1:0] r_sr;
  logic [IW-1:0] r_idx;
  logic          r_last;
  logic          r_owner;
  logic [1:0]    r_gnt;
  logic [CW-1:0] r_c011;
  logic [CW-1:0] r_c100;

  logic w_any;
  logic w_win;
  logic w_start;
  logic w_s;
  logic w_cnt_en;
  logic w_last_bit;
  logic w_hit011;
  logic w_hit100;

  // Arbitration: a lone requester wins outright; on a tie the one not served last wins
  assign w_any      = bus.req0 | bus.req1;
  assign w_win      = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_start    = (r_ctl == ST_IDLE) && w_any;
  assign w_s        = (r_ctl == ST_SHIFT) ? r_sr[DW-1] : 1'b0;
  assign w_cnt_en   = (r_ctl == ST_SHIFT) || (r_ctl == ST_FLUSH);
  assign w_last_bit = (r_idx == IW'(DW - 1));

  // Controller: IDLE -> SHIFT (DW bits) -> FLUSH -> DONE -> IDLE
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      r_ctl <= ST_IDLE;
    end else begin
      case (r_ctl)
        ST_IDLE:  if (w_any) r_ctl <= ST_SHIFT;
        ST_SHIFT: if (w_last_bit) r_ctl <= ST_FLUSH;
        ST_FLUSH: r_ctl <= ST_DONE;
        default:  r_ctl <= ST_IDLE;
      endcase
    end
  end

  // Word latch, MSB-first shifter, bit index, owner and round-robin pointer
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      r_sr    <= '0;
      r_idx   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_gnt   <= '0;
    end else begin
      r_gnt <= '0;
      if (w_start) begin
        r_sr    <= w_win ? bus.data1 : bus.data0;
        r_idx   <= '0;
        r_owner <= w_win;
        r_last  <= w_win;
        r_gnt   <= onehot2(w_win);
      end else if (r_ctl == ST_SHIFT) begin
        r_sr  <= {r_sr[DW-2:0], 1'b0};
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Saturating hit counters; the FLUSH cycle picks up the hit caused by the last bit
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      r_c011 <= '0;
      r_c100 <= '0;
    end else if (w_start) begin
      r_c011 <= '0;
      r_c100 <= '0;
    end else if (w_cnt_en) begin
      if (w_hit011 && (r_c011 != '1)) r_c011 <= r_c011 + 1'b1;
      if (w_hit100 && (r_c100 != '1)) r_c100 <= r_c100 + 1'b1;
    end
  end

  // Core is cleared on the grant edge; whatever it does outside SHIFT/FLUSH is never counted
  seq_det_core u_core (
    .ck     (ck),
    .rs     (rs),
    .clr    (w_start),
    .s      (w_s),
    .hit011 (w_hit011),
    .hit100 (w_hit100)
  );

  assign bus.gnt    = r_gnt;
  assign bus.busy   = (r_ctl != ST_IDLE);
  assign bus.s_out  = w_s;
  assign bus.done   = (r_ctl == ST_DONE);
  assign bus.owner  = r_owner;
  assign bus.cnt011 = r_c011;
  assign bus.cnt100 = r_c100;

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: stimulus queues hand-computed frame
// results, a monitor captures grant/serial stream and checks them at done.
module tb_seq_det_sched;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic ck = 1'b0;
  logic rs = 1'b1;
  always #5 ck = ~ck;

  seq_det_sched_if #(.DW(DW), .CW(CW)) bus ();
  seq_det_sched_if #(.DW(DW), .CW(1))  sbus ();

  seq_det_sched #(.DW(DW), .CW(CW)) dut (.ck(ck), .rs(rs), .bus(bus));
  // Narrow-counter copy running the same traffic, to exercise saturation
  seq_det_sched #(.DW(DW), .CW(1)) dut_sat (.ck(ck), .rs(rs), .bus(sbus));

  assign sbus.req0  = bus.req0;
  assign sbus.data0 = bus.data0;
  assign sbus.req1  = bus.req1;
  assign sbus.data1 = bus.data1;

  typedef struct {
    logic [1:0]    gnt;
    logic [DW-1:0] word;
    logic          owner;
    logic [CW-1:0] c011;
    logic [CW-1:0] c100;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic push_exp(input logic w, input logic [DW-1:0] d,
                          input logic [CW-1:0] c011, input logic [CW-1:0] c100);
    exp_t e;
    e.gnt   = w ? 2'b10 : 2'b01;
    e.word  = d;
    e.owner = w;
    e.c011  = c011;
    e.c100  = c100;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(output int unsigned at);
    bit seen;
    seen = 1'b0;
    at   = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge ck);
      seen = (bus.gnt != 2'b00);
    end
    if (seen) at = cyc;
    else check("gnt_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge ck);
      seen = bus.done;
    end
    if (!seen) check("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic send(input logic w, input logic [DW-1:0] d,
                      input logic [CW-1:0] c011, input logic [CW-1:0] c100);
    int unsigned t;
    @(posedge ck); #1;
    if (w) begin bus.req1 = 1'b1; bus.data1 = d; end
    else   begin bus.req0 = 1'b1; bus.data0 = d; end
    push_exp(w, d, c011, c100);
    wait_gnt(t);
    @(posedge ck); #1;
    if (w) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
    wait_done();
  endtask

  // Monitor: capture grant and the serial stream of each frame, check at done
  initial begin
    logic          cap_on;
    logic [1:0]    cap_gnt;
    logic [DW-1:0] cap_word;
    int unsigned   cap_n;
    int unsigned   gcyc;
    exp_t          e;
    cap_on = 1'b0; cap_gnt = '0; cap_word = '0; cap_n = 0; gcyc = 0;
    forever begin
      @(negedge ck);
      if (rs) begin
        cap_on = 1'b0;
      end else begin
        if (bus.gnt != 2'b00) begin
          cap_on = 1'b1; cap_gnt = bus.gnt; cap_n = 0; gcyc = cyc;
        end
        if (cap_on && cap_n < DW) begin
          cap_word = {cap_word[DW-2:0], bus.s_out};
          cap_n++;
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", {31'd0, bus.done}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("grant",       {30'd0, cap_gnt},    {30'd0, e.gnt});
            check("serial_word", {24'd0, cap_word},   {24'd0, e.word});
            check("latency",     cyc - gcyc,          DW + 1);
            check("owner",       {31'd0, bus.owner},  {31'd0, e.owner});
            check("cnt011",      {28'd0, bus.cnt011}, {28'd0, e.c011});
            check("cnt100",      {28'd0, bus.cnt100}, {28'd0, e.c100});
            check("s_out_done",  {31'd0, bus.s_out},  32'd0);
            check("sat_cnt011",  {31'd0, sbus.cnt011}, {31'd0, (e.c011 != 0)});
            check("sat_cnt100",  {31'd0, sbus.cnt100}, {31'd0, (e.c100 != 0)});
          end
          cap_on = 1'b0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int unsigned t0, t1, t2;
    bus.req0 = 1'b0; bus.data0 = '0; bus.req1 = 1'b0; bus.data1 = '0;
    rs = 1'b1;
    repeat (3) @(posedge ck);
    #1 rs = 1'b0;

    // Idle after reset
    repeat (2) @(negedge ck);
    check("rst_busy",   {31'd0, bus.busy},   32'd0);
    check("rst_gnt",    {30'd0, bus.gnt},    32'd0);
    check("rst_done",   {31'd0, bus.done},   32'd0);
    check("rst_s_out",  {31'd0, bus.s_out},  32'd0);
    check("rst_owner",  {31'd0, bus.owner},  32'd0);
    check("rst_cnt011", {28'd0, bus.cnt011}, 32'd0);
    check("rst_cnt100", {28'd0, bus.cnt100}, 32'd0);

    // Single requests
    send(1'b0, 8'b0110_1100, 4'd2, 4'd1);
    send(1'b1, 8'b1001_0010, 4'd0, 4'd2);
    send(1'b1, 8'hFF,        4'd0, 4'd0);
    send(1'b1, 8'h00,        4'd0, 4'd0);

    // Both requesting from reset: 01, 10, 01 at an 11-cycle period
    @(posedge ck); #1;
    rs = 1'b1;
    bus.req0 = 1'b1; bus.data0 = 8'b0110_1100;
    bus.req1 = 1'b1; bus.data1 = 8'b1001_0010;
    push_exp(1'b0, 8'b0110_1100, 4'd2, 4'd1);
    push_exp(1'b1, 8'b1001_0010, 4'd0, 4'd2);
    push_exp(1'b0, 8'b0110_1100, 4'd2, 4'd1);
    @(posedge ck); #1 rs = 1'b0;
    wait_gnt(t0);
    wait_gnt(t1);
    wait_gnt(t2);
    @(posedge ck); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("period_01_10", t1 - t0, DW + 3);
    check("period_10_01", t2 - t1, DW + 3);
    wait_done();

    // Reset during bit 4 of a frame, then the held request is served again
    @(posedge ck); #1;
    bus.req0 = 1'b1; bus.data0 = 8'b0110_1100;
    wait_gnt(t0);
    repeat (4) @(posedge ck);
    #1 rs = 1'b1;
    #1;
    check("abort_busy",   {31'd0, bus.busy},   32'd0);
    check("abort_gnt",    {30'd0, bus.gnt},    32'd0);
    check("abort_s_out",  {31'd0, bus.s_out},  32'd0);
    check("abort_done",   {31'd0, bus.done},   32'd0);
    check("abort_owner",  {31'd0, bus.owner},  32'd0);
    check("abort_cnt011", {28'd0, bus.cnt011}, 32'd0);
    check("abort_cnt100", {28'd0, bus.cnt100}, 32'd0);
    @(posedge ck); #1 rs = 1'b0;
    push_exp(1'b0, 8'b0110_1100, 4'd2, 4'd1);
    wait_gnt(t0);
    @(posedge ck); #1 bus.req0 = 1'b0;
    wait_done();

    // Data changed after grant: counts follow the latched word
    @(posedge ck); #1;
    bus.req0 = 1'b1; bus.data0 = 8'b0110_1100;
    push_exp(1'b0, 8'b0110_1100, 4'd2, 4'd1);
    wait_gnt(t0);
    @(posedge ck); #1;
    bus.req0 = 1'b0; bus.data0 = 8'h00;
    wait_done();

    // Frame A ends ...01, frame B starts 11: no 011 hit may span the boundary
    @(posedge ck); #1;
    bus.req0 = 1'b1; bus.data0 = 8'b0000_0001;
    push_exp(1'b0, 8'b0000_0001, 4'd0, 4'd0);
    wait_gnt(t0);
    @(posedge ck); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.data1 = 8'b1100_0000;
    push_exp(1'b1, 8'b1100_0000, 4'd0, 4'd1);
    wait_gnt(t1);
    @(posedge ck); #1 bus.req1 = 1'b0;
    check("boundary_period", t1 - t0, DW + 3);
    wait_done();

    repeat (4) @(negedge ck);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
